// File: rtl/reg_file_mp.sv
// ============================================================================
//  Module   : reg_file_mp
//  Purpose  : Parametrised 1W/2R register file with bypass, optional zero
//             register, pending scoreboard and sequenced clear.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module reg_file_mp #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [DATA_W-1:0] IN,
  input  logic [ADDR_W-1:0] INADDRESS,
  input  logic              WRITE,
  input  logic              RESERVE,
  input  logic [ADDR_W-1:0] RESADDRESS,
  input  logic              CLEAR,
  input  logic [ADDR_W-1:0] OUT1ADDRESS,
  input  logic [ADDR_W-1:0] OUT2ADDRESS,
  output logic [DATA_W-1:0] OUT1,
  output logic [DATA_W-1:0] OUT2,
  output logic              OUT1_READY,
  output logic              OUT2_READY,
  output logic              BUSY
);

  localparam int          DEPTH    = 2 ** ADDR_W;
  localparam logic        ZR       = (ZERO_REG != 0);
  localparam logic        BYP      = (BYPASS != 0);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    S_IDLE     = 1'b0,
    S_CLEARING = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]  pending_q;

  logic w_we;
  logic w_rsv;
  logic w_byp1;
  logic w_byp2;

  assign BUSY  = (state_q == S_CLEARING);
  assign w_we  = WRITE   & ~BUSY & ~(ZR & (INADDRESS == '0));
  assign w_rsv = RESERVE & ~BUSY & ~(ZR & (RESADDRESS == '0));

  assign w_byp1 = BYP & w_we & (INADDRESS == OUT1ADDRESS);
  assign w_byp2 = BYP & w_we & (INADDRESS == OUT2ADDRESS);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (CLEAR) begin
          state_d = S_CLEARING;
          idx_d   = '0;
        end
      end
      S_CLEARING: begin
        // idx wraps to 0 naturally on the last entry
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Writes and reserves are masked while clearing, so they never collide with idx
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      pending_q <= '0;
    end else if (BUSY) begin
      regs_q[idx_q]    <= '0;
      pending_q[idx_q] <= 1'b0;
    end else begin
      if (w_we) begin
        regs_q[INADDRESS]    <= IN;
        pending_q[INADDRESS] <= 1'b0;
      end
      // Reserve after write: a same-address reserve names the new producer
      if (w_rsv) begin
        pending_q[RESADDRESS] <= 1'b1;
      end
    end
  end

  assign OUT1 = (ZR && (OUT1ADDRESS == '0)) ? '0 :
                w_byp1                      ? IN : regs_q[OUT1ADDRESS];
  assign OUT2 = (ZR && (OUT2ADDRESS == '0)) ? '0 :
                w_byp2                      ? IN : regs_q[OUT2ADDRESS];

  assign OUT1_READY = BUSY                        ? 1'b0 :
                      (ZR && (OUT1ADDRESS == '0)) ? 1'b1 :
                      (~pending_q[OUT1ADDRESS] | w_byp1);
  assign OUT2_READY = BUSY                        ? 1'b0 :
                      (ZR && (OUT2ADDRESS == '0)) ? 1'b1 :
                      (~pending_q[OUT2ADDRESS] | w_byp2);

endmodule

`default_nettype wire

// File: tb/tb_reg_file_mp.sv
// ============================================================================
//  Module   : tb_reg_file_mp
//  Purpose  : Directed, table-driven bench for reg_file_mp in three configs.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_reg_file_mp;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Shared stimulus for instance A (bypass, no zero reg) and B (zero reg, no bypass)
  logic       RESET = 1'b1;
  logic [7:0] in8 = '0;
  logic [2:0] wa = '0, ra = '0, a1 = '0, a2 = '0;
  logic       wr = 1'b0, rsv = 1'b0, clr = 1'b0;
  logic [7:0] oA1, oA2, oB1, oB2;
  logic       rA1, rA2, rB1, rB2, bA, bB;

  // Instance C: 16-bit, 16-entry
  logic [15:0] inC = '0;
  logic [3:0]  waC = '0, a1C = '0, a2C = '0;
  logic        wrC = 1'b0, clrC = 1'b0;
  logic [15:0] oC1, oC2;
  logic        rC1, rC2, bC;

  int n_chk  = 0;
  int n_fail = 0;

  reg_file_mp #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(0), .BYPASS(1)) u_a (
    .CLK(CLK), .RESET(RESET), .IN(in8), .INADDRESS(wa), .WRITE(wr),
    .RESERVE(rsv), .RESADDRESS(ra), .CLEAR(clr),
    .OUT1ADDRESS(a1), .OUT2ADDRESS(a2), .OUT1(oA1), .OUT2(oA2),
    .OUT1_READY(rA1), .OUT2_READY(rA2), .BUSY(bA)
  );

  reg_file_mp #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(1), .BYPASS(0)) u_b (
    .CLK(CLK), .RESET(RESET), .IN(in8), .INADDRESS(wa), .WRITE(wr),
    .RESERVE(rsv), .RESADDRESS(ra), .CLEAR(clr),
    .OUT1ADDRESS(a1), .OUT2ADDRESS(a2), .OUT1(oB1), .OUT2(oB2),
    .OUT1_READY(rB1), .OUT2_READY(rB2), .BUSY(bB)
  );

  reg_file_mp #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(0), .BYPASS(1)) u_c (
    .CLK(CLK), .RESET(RESET), .IN(inC), .INADDRESS(waC), .WRITE(wrC),
    .RESERVE(1'b0), .RESADDRESS(4'd0), .CLEAR(clrC),
    .OUT1ADDRESS(a1C), .OUT2ADDRESS(a2C), .OUT1(oC1), .OUT2(oC2),
    .OUT1_READY(rC1), .OUT2_READY(rC2), .BUSY(bC)
  );

  typedef struct {
    logic       wr;
    logic [2:0] wa;
    logic [7:0] wd;
    logic       rsv;
    logic [2:0] ra;
    logic [2:0] a1, a2;
    logic [7:0] ea1, ea2;
    logic       era1, era2;
    logic [7:0] eb1, eb2;
    logic       erb1, erb2;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    //            wr wa    wd     rsv ra    a1    a2    ea1    ea2    r1 r2  eb1    eb2    r1 r2
    tbl[0]  = '{1, 3'd3, 8'hA5, 0, 3'd0, 3'd3, 3'd3, 8'hA5, 8'hA5, 1, 1, 8'h00, 8'h00, 1, 1};
    tbl[1]  = '{0, 3'd0, 8'h00, 0, 3'd0, 3'd3, 3'd0, 8'hA5, 8'h00, 1, 1, 8'hA5, 8'h00, 1, 1};
    tbl[2]  = '{0, 3'd0, 8'h00, 1, 3'd5, 3'd5, 3'd5, 8'h00, 8'h00, 1, 1, 8'h00, 8'h00, 1, 1};
    tbl[3]  = '{0, 3'd0, 8'h00, 0, 3'd0, 3'd3, 3'd5, 8'hA5, 8'h00, 1, 0, 8'hA5, 8'h00, 1, 0};
    tbl[4]  = '{1, 3'd5, 8'h3C, 0, 3'd0, 3'd5, 3'd5, 8'h3C, 8'h3C, 1, 1, 8'h00, 8'h00, 0, 0};
    tbl[5]  = '{0, 3'd0, 8'h00, 0, 3'd0, 3'd5, 3'd5, 8'h3C, 8'h3C, 1, 1, 8'h3C, 8'h3C, 1, 1};
    tbl[6]  = '{1, 3'd5, 8'h3C, 1, 3'd5, 3'd3, 3'd5, 8'hA5, 8'h3C, 1, 1, 8'hA5, 8'h3C, 1, 1};
    tbl[7]  = '{0, 3'd0, 8'h00, 0, 3'd0, 3'd5, 3'd5, 8'h3C, 8'h3C, 0, 0, 8'h3C, 8'h3C, 0, 0};
    tbl[8]  = '{1, 3'd0, 8'h77, 0, 3'd0, 3'd0, 3'd0, 8'h77, 8'h77, 1, 1, 8'h00, 8'h00, 1, 1};
    tbl[9]  = '{0, 3'd0, 8'h00, 0, 3'd0, 3'd0, 3'd3, 8'h77, 8'hA5, 1, 1, 8'h00, 8'hA5, 1, 1};
    tbl[10] = '{0, 3'd0, 8'h00, 1, 3'd0, 3'd0, 3'd0, 8'h77, 8'h77, 1, 1, 8'h00, 8'h00, 1, 1};
    tbl[11] = '{0, 3'd0, 8'h00, 0, 3'd0, 3'd0, 3'd1, 8'h77, 8'h00, 0, 1, 8'h00, 8'h00, 1, 1};
    tbl[12] = '{1, 3'd1, 8'h11, 0, 3'd0, 3'd1, 3'd0, 8'h11, 8'h77, 1, 0, 8'h00, 8'h00, 1, 1};
    tbl[13] = '{0, 3'd0, 8'h00, 0, 3'd0, 3'd1, 3'd1, 8'h11, 8'h11, 1, 1, 8'h11, 8'h11, 1, 1};

    // Reset and readback
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    for (int i = 0; i < 8; i++) begin
      a1 = 3'(i);
      a2 = 3'(7 - i);
      #1;
      chk("reset_out1", 32'(oA1), 32'h0);
      chk("reset_out2", 32'(oA2), 32'h0);
      chk("reset_rdy1", 32'(rA1), 32'h1);
      chk("reset_rdy2", 32'(rA2), 32'h1);
    end
    chk("reset_busyA", 32'(bA), 32'h0);
    chk("reset_busyB", 32'(bB), 32'h0);
    chk("reset_busyC", 32'(bC), 32'h0);

    // Write / bypass / scoreboard / zero-register vectors
    for (int i = 0; i < 14; i++) begin
      wr = tbl[i].wr; wa = tbl[i].wa; in8 = tbl[i].wd;
      rsv = tbl[i].rsv; ra = tbl[i].ra; a1 = tbl[i].a1; a2 = tbl[i].a2;
      #1;
      chk($sformatf("vecA%0d_out1", i), 32'(oA1), 32'(tbl[i].ea1));
      chk($sformatf("vecA%0d_out2", i), 32'(oA2), 32'(tbl[i].ea2));
      chk($sformatf("vecA%0d_rdy1", i), 32'(rA1), 32'(tbl[i].era1));
      chk($sformatf("vecA%0d_rdy2", i), 32'(rA2), 32'(tbl[i].era2));
      chk($sformatf("vecB%0d_out1", i), 32'(oB1), 32'(tbl[i].eb1));
      chk($sformatf("vecB%0d_out2", i), 32'(oB2), 32'(tbl[i].eb2));
      chk($sformatf("vecB%0d_rdy1", i), 32'(rB1), 32'(tbl[i].erb1));
      chk($sformatf("vecB%0d_rdy2", i), 32'(rB2), 32'(tbl[i].erb2));
      step();
    end
    wr = 1'b0; rsv = 1'b0;

    // Fill r0..r7 with 0x10..0x17, then a sequenced clear
    for (int i = 0; i < 8; i++) begin
      wr = 1'b1; wa = 3'(i); in8 = 8'h10 + 8'(i);
      step();
    end
    wr = 1'b0;
    clr = 1'b1;
    step();
    clr = 1'b0;
    for (int j = 0; j < 8; j++) begin
      a1 = 3'(j);
      a2 = (j == 0) ? 3'd7 : 3'(j - 1);
      wr = (j == 3); wa = 3'd7; in8 = 8'h99;
      #1;
      chk($sformatf("clr%0d_busyA", j), 32'(bA), 32'h1);
      chk($sformatf("clr%0d_busyB", j), 32'(bB), 32'h1);
      chk($sformatf("clr%0d_notyet", j), 32'(oA1), 32'(8'h10 + 8'(j)));
      chk($sformatf("clr%0d_prev", j), 32'(oA2), (j == 0) ? 32'h17 : 32'h0);
      chk($sformatf("clr%0d_rdy", j), 32'(rA1), 32'h0);
      step();
    end
    wr = 1'b0;
    a1 = 3'd7;
    #1;
    chk("clr_done_busy", 32'(bA), 32'h0);
    chk("clr_lost_write", 32'(oA1), 32'h0);
    chk("clr_done_rdy", 32'(rA1), 32'h1);
    wr = 1'b1; wa = 3'd7; in8 = 8'h42;
    step();
    wr = 1'b0;
    #1;
    chk("post_clr_write", 32'(oA1), 32'h42);

    // Reset in the middle of a clear
    wr = 1'b1; wa = 3'd6; in8 = 8'h66;
    step();
    wr = 1'b0;
    clr = 1'b1;
    step();
    clr = 1'b0;
    step();
    step();
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    a1 = 3'd6; a2 = 3'd7;
    #1;
    chk("midrst_busy", 32'(bA), 32'h0);
    chk("midrst_r6", 32'(oA1), 32'h0);
    chk("midrst_r7", 32'(oA2), 32'h0);
    chk("midrst_rdy", 32'(rA1), 32'h1);
    step();
    chk("midrst_busy_next", 32'(bA), 32'h0);

    // Wider configuration
    wrC = 1'b1; waC = 4'd15; inC = 16'hBEEF; a1C = 4'd15; a2C = 4'd14;
    #1;
    chk("c_bypass", 32'(oC1), 32'hBEEF);
    chk("c_other", 32'(oC2), 32'h0);
    step();
    wrC = 1'b0;
    #1;
    chk("c_readback", 32'(oC1), 32'hBEEF);
    chk("c_rdy", 32'(rC1), 32'h1);
    clrC = 1'b1;
    step();
    clrC = 1'b0;
    cnt = 0;
    while (bC && cnt < 40) begin
      step();
      cnt++;
    end
    chk("c_clear_cycles", 32'(cnt), 32'd16);
    chk("c_cleared", 32'(oC1), 32'h0);
    chk("c_rdy2", 32'(rC2), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised successor to the CPU's 8×8 register file: a DEPTH-entry, DATA_W-bit register file with one write port and two asynchronous read ports. It adds write-to-read bypass, an optional hardwired-zero register 0, and a per-register pending scoreboard for the control unit's hazard checks. A sequenced CLEAR wipes the file one entry per cycle without a global reset. It sits between the instruction decoder (addresses, RESERVE) and the ALU (operands, result write-back).

## Interface
- DATA_W, 8: register width in bits.
- ADDR_W, 3: address width; DEPTH = 2**ADDR_W entries.
- ZERO_REG, 0: 1 makes register 0 read as zero and ignore writes and reserves.
- BYPASS, 1: 1 forwards an effective same-cycle write to matching read ports.

- CLK  in  1  clock; all state updates on posedge.
- RESET  in  1  synchronous, active-high reset.
- IN  in  DATA_W  write data.
- INADDRESS  in  ADDR_W  write address.
- WRITE  in  1  write enable.
- RESERVE  in  1  mark register RESADDRESS pending.
- RESADDRESS  in  ADDR_W  reserve address.
- CLEAR  in  1  start sequenced clear; sampled only when idle.
- OUT1ADDRESS, OUT2ADDRESS  in  ADDR_W  read addresses.
- OUT1, OUT2  out  DATA_W  read data, combinational.
- OUT1_READY, OUT2_READY  out  1  addressed register has no pending producer.
- BUSY  out  1  clear sequence in progress.

## Operation
- State: regs[DEPTH], pending[DEPTH], FSM {IDLE, CLEARING}, index counter idx (ADDR_W bits).
- RESET (highest priority): all regs 0, all pending 0, FSM IDLE, idx 0. After reset: OUTn = 0, OUTn_READY = 1, BUSY = 0.
- Effective write (we) = WRITE & ~BUSY & ~(ZERO_REG & INADDRESS==0). On posedge: regs[INADDRESS] <= IN and pending[INADDRESS] <= 0.
- Effective reserve = RESERVE & ~BUSY & ~(ZERO_REG & RESADDRESS==0). On posedge: pending[RESADDRESS] <= 1.
- If write and reserve target the same address in the same cycle, the data is written and the pending bit ends at 1 (the reserve names a new producer).
- OUTn: 0 if ZERO_REG and address==0; else IN if BYPASS and we and INADDRESS==OUTnADDRESS; else regs[OUTnADDRESS].
- OUTn_READY: 0 while BUSY. Otherwise 1 if ZERO_REG and address==0. Otherwise ~pending[addr] | (BYPASS & we & INADDRESS==addr).
- Both read ports are independent. The same address on both ports is legal and returns identical data.
- FSM transitions:
  - IDLE → CLEARING on CLEAR (RESET low), with idx <= 0.
  - In CLEARING, each edge sets regs[idx] <= 0, pending[idx] <= 0, idx <= idx+1.
  - When idx==DEPTH-1, the FSM returns to IDLE and idx wraps to 0.
- BUSY = (FSM==CLEARING).
- While BUSY, WRITE, RESERVE and CLEAR are ignored (dropped, not queued). Reads return current contents, which may be partially cleared.

## Timing
- Read latency 0: outputs are combinational from state and bypass inputs.
- Write and reserve take effect at the sampling edge and are visible without bypass from the next cycle.
- CLEAR sampled at edge k:
  - BUSY is high from after edge k through edge k+DEPTH.
  - Register i is zeroed at edge k+1+i.
  - The first accepted write is at edge k+DEPTH+1.
- RESET mid-clear: at that edge all state is zeroed, the FSM goes to IDLE and BUSY drops. The clear is not resumed.
- A CLEAR held high continuously restarts a new sequence on the first idle edge after the previous one completes.

## Test plan
- Reset and readback (DATA_W=8, ADDR_W=3): assert RESET one edge, then read all 8 addresses → OUTn=0x00, OUTn_READY=1, BUSY=0.
- Write, bypass and collision:
  - WRITE 0xA5 to r3 with OUT1ADDRESS=3 in the same cycle → OUT1=0xA5 before the edge (BYPASS=1) and 0xA5 after it.
  - With BYPASS=0 → OUT1=old value before the edge.
- ZERO_REG=1: write 0xFF to r0 and RESERVE r0 → OUT1=0x00, OUT1_READY=1 throughout. Write 0x11 to r1 → reads 0x11.
- Scoreboard:
  - RESERVE r5 → OUT2_READY=0 next cycle. WRITE 0x3C to r5 → OUT2_READY=1 combinationally in that cycle (BYPASS=1), and 1 afterwards.
  - Simultaneous WRITE and RESERVE to r5 → data 0x3C, OUT2_READY=0 afterwards.
- Clear sequence:
  - Fill r0–r7 with 0x10–0x17, then pulse CLEAR → BUSY high for 8 cycles, r0..r7 read 0 one per cycle in order.
  - A WRITE 0x99 to r7 during BUSY is lost → r7=0x00 after completion. A write on the following cycle succeeds.
- Reset mid-clear and width generality:
  - RESET at clear cycle 3 → all regs 0, BUSY 0 next cycle.
  - Repeat write/read with DATA_W=16, ADDR_W=4 → 0xBEEF to r15 reads back 0xBEEF, and a clear takes 16 cycles.
